// File: rtl/fpga_reset_sequencer.sv
// fpga_reset_sequencer
//   Front-end reset source for the board clocking. After power-up, a lock
//   loss or a user button press, it pulses mmcm_reset. It then waits until
//   every MMCM lock has been stable for LOCK_STABLE_CYCLES before it releases
//   sys_reset. A WAIT_LOCK that lasts LOCK_TIMEOUT_CYCLES re-pulses the MMCMs.
//   Lock timeouts and lock losses in RUN are counted in fault_count, which
//   saturates at 255.
//
// Optional feature macro: RESET_SEQ_BUTTON_EN
//   defined   -> the button synchronizer and debouncer are built.
//   undefined -> the button port is ignored.
//
// Ports
//   clock       in  free-running reference clock (not from an MMCM)
//   areset      in  asynchronous active-high reset (power-on / PS reset)
//   button      in  asynchronous active-high user reset button
//   locked      in  [NUM_LOCKS] asynchronous MMCM/PLL lock flags
//   mmcm_reset  out registered reset to the MMCM(s)
//   sys_reset   out registered active-high reset for the downstream chain
//   state       out [3] FSM state: 0 RST, 1 PULSE, 2 WAIT_LOCK, 3 STABLE, 4 RUN
//   fault_count out [8] saturating count of lock timeouts and lock losses
`timescale 1ns/1ps
module fpga_reset_sequencer #(
  parameter int NUM_LOCKS           = 2,
  parameter int MMCM_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int BTN_DEBOUNCE_BITS   = 16
) (
  input  logic                 clock,
  input  logic                 areset,
  input  logic                 button,
  input  logic [NUM_LOCKS-1:0] locked,
  output logic                 mmcm_reset,
  output logic                 sys_reset,
  output logic [2:0]           state,
  output logic [7:0]           fault_count
);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_PULSE     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  // The shared state counter must hold the largest cycle parameter.
  localparam int CNT_MAX_AB = (MMCM_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                              MMCM_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                              CNT_MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_TOP      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic [NUM_LOCKS-1:0] lock_meta_q;
  logic [NUM_LOCKS-1:0] lock_sync_q;
  logic                 all_locked_s;
  logic                 btn_press_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       fault_q, fault_d;
  logic             mmcm_reset_q, mmcm_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic             fault_s;
  logic             restart_s;

  // Two-flop synchronizer for the asynchronous lock flags.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      lock_meta_q <= '0;
      lock_sync_q <= '0;
    end else begin
      lock_meta_q <= locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign all_locked_s = &lock_sync_q;

`ifdef RESET_SEQ_BUTTON_EN
  localparam logic [BTN_DEBOUNCE_BITS-1:0] BTN_ONE = BTN_DEBOUNCE_BITS'(1'b1);

  logic                         btn_meta_q, btn_sync_q;
  logic                         btn_stable_q, btn_stable_d;
  logic                         btn_press_q, btn_press_d;
  logic [BTN_DEBOUNCE_BITS-1:0] btn_cnt_q, btn_cnt_d;

  // Debouncer: the synchronized level must differ from the accepted level for
  // 2^BTN_DEBOUNCE_BITS consecutive clocks; any bounce restarts the count.
  always_comb begin
    btn_stable_d = btn_stable_q;
    btn_press_d  = 1'b0;
    btn_cnt_d    = '0;
    if (btn_sync_q != btn_stable_q) begin
      if (&btn_cnt_q) begin
        btn_stable_d = btn_sync_q;
        btn_press_d  = btn_sync_q;  // only a rising edge is a press
      end else begin
        btn_cnt_d = btn_cnt_q + BTN_ONE;
      end
    end else begin
      btn_cnt_d = '0;
    end
  end

  // Button synchronizer and debounce state registers.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      btn_stable_q <= 1'b0;
      btn_press_q  <= 1'b0;
      btn_cnt_q    <= '0;
    end else begin
      btn_meta_q   <= button;
      btn_sync_q   <= btn_meta_q;
      btn_stable_q <= btn_stable_d;
      btn_press_q  <= btn_press_d;
      btn_cnt_q    <= btn_cnt_d;
    end
  end

  assign btn_press_s = btn_press_q;
`else
  logic unused_button_s;
  assign unused_button_s = button;
  assign btn_press_s     = 1'b0;
`endif

  // Next-state, counter, fault and registered-output logic.
  always_comb begin
    state_d   = state_q;
    fault_s   = 1'b0;
    restart_s = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (btn_press_s) begin
          restart_s = 1'b1;
        end else if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_WAIT_LOCK: begin
        // A timeout is counted even when a press arrives in the same cycle.
        if (!all_locked_s && (cnt_q == TIMEOUT_LAST)) begin
          state_d = ST_PULSE;
          fault_s = 1'b1;
        end else if (btn_press_s) begin
          state_d = ST_PULSE;
        end else if (all_locked_s) begin
          state_d = ST_STABLE;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!all_locked_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (btn_press_s) begin
          state_d = ST_PULSE;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_RUN: begin
        // Lock loss wins over a coincident press: one PULSE, one increment.
        if (!all_locked_s) begin
          state_d = ST_PULSE;
          fault_s = 1'b1;
        end else if (btn_press_s) begin
          state_d = ST_PULSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    // Counter clears on every state entry; it holds at its top in RUN.
    if (restart_s || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    if (fault_s && (fault_q != 8'hFF)) begin
      fault_d = fault_q + 8'd1;
    end else begin
      fault_d = fault_q;
    end

    mmcm_reset_d = (state_d == ST_PULSE) || (state_d == ST_RST);
    sys_reset_d  = (state_d != ST_RUN);
  end

  // State register; areset forces RST and raises both resets at once.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_q      <= ST_RST;
      cnt_q        <= '0;
      fault_q      <= 8'd0;
      mmcm_reset_q <= 1'b1;
      sys_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      mmcm_reset_q <= mmcm_reset_d;
      sys_reset_q  <= sys_reset_d;
    end
  end

  assign mmcm_reset  = mmcm_reset_q;
  assign sys_reset   = sys_reset_q;
  assign state       = state_q;
  assign fault_count = fault_q;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// tb_fpga_reset_sequencer
//   Directed bench for fpga_reset_sequencer with MMCM_RST_CYCLES=4,
//   LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, BTN_DEBOUNCE_BITS=3.
//   Edges are counted from the first rising edge with areset low (edge 1);
//   outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_fpga_reset_sequencer;

  logic       clock = 1'b0;
  logic       areset;
  logic       button;
  logic [1:0] locked;
  logic       mmcm_reset;
  logic       sys_reset;
  logic [2:0] state;
  logic [7:0] fault_count;

  int n_cmp  = 0;
  int n_fail = 0;

  fpga_reset_sequencer #(
    .NUM_LOCKS          (2),
    .MMCM_RST_CYCLES    (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .BTN_DEBOUNCE_BITS  (3)
  ) dut (
    .clock      (clock),
    .areset     (areset),
    .button     (button),
    .locked     (locked),
    .mmcm_reset (mmcm_reset),
    .sys_reset  (sys_reset),
    .state      (state),
    .fault_count(fault_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Power-up timing with locked=11 held: mmcm_reset falls at edge 5,
  // WAIT_LOCK at 5, STABLE at 6, sys_reset falls / RUN at edge 14.
  task automatic powerup_check(input string tag);
    for (int e = 1; e <= 14; e++) begin
      tick();
      check({tag, "_mmcm"}, 32'(mmcm_reset), 32'(e < 5));
      check({tag, "_sys"},  32'(sys_reset),  32'(e < 14));
      check({tag, "_state"}, 32'(state),
            (e < 5) ? 32'd1 : (e < 6) ? 32'd2 : (e < 14) ? 32'd3 : 32'd4);
    end
    check({tag, "_fault"}, 32'(fault_count), 32'd0);
  endtask

  initial begin
    areset = 1'b1;
    button = 1'b0;
    locked = 2'b11;

    // Reset state.
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_mmcm",  32'(mmcm_reset), 32'd1);
    check("rst_sys",   32'(sys_reset), 32'd1);
    check("rst_fault", 32'(fault_count), 32'd0);

    // Power-up.
    @(negedge clock);
    areset = 1'b0;
    powerup_check("pwr");

    // Lock loss in RUN: resets rise on the 3rd edge after locked[0] falls.
    repeat (3) tick();
    locked = 2'b10;
    tick();
    check("loss_e1_sys", 32'(sys_reset), 32'd0);
    tick();
    check("loss_e2_sys", 32'(sys_reset), 32'd0);
    check("loss_e2_mmcm", 32'(mmcm_reset), 32'd0);
    tick();  // edge P: PULSE entered
    check("loss_e3_sys", 32'(sys_reset), 32'd1);
    check("loss_e3_mmcm", 32'(mmcm_reset), 32'd1);
    check("loss_e3_state", 32'(state), 32'd1);
    check("loss_fault", 32'(fault_count), 32'd1);
    locked = 2'b11;

    // Repeated sequence with a 1-cycle glitch on locked[1] at STABLE count 5.
    repeat (3) tick();  // P+3
    check("rep_p3_mmcm", 32'(mmcm_reset), 32'd1);
    tick();             // P+4
    check("rep_p4_mmcm", 32'(mmcm_reset), 32'd0);
    check("rep_p4_state", 32'(state), 32'd2);
    tick();             // P+5 STABLE, count 0
    check("rep_p5_state", 32'(state), 32'd3);
    repeat (5) tick();  // P+10, STABLE count 5
    locked = 2'b01;
    tick();             // P+11
    locked = 2'b11;
    tick();             // P+12
    check("glitch_p12_state", 32'(state), 32'd3);
    tick();             // P+13: glitch reaches the FSM
    check("glitch_p13_state", 32'(state), 32'd2);
    check("glitch_p13_sys", 32'(sys_reset), 32'd1);
    check("glitch_fault", 32'(fault_count), 32'd1);
    tick();             // P+14: STABLE again
    check("glitch_p14_state", 32'(state), 32'd3);
    repeat (7) tick();  // P+21
    check("glitch_p21_sys", 32'(sys_reset), 32'd1);
    tick();             // P+22: 8 clean cycles later
    check("glitch_p22_sys", 32'(sys_reset), 32'd0);
    check("glitch_p22_state", 32'(state), 32'd4);

    // Button with three 3-cycle bounces, then a stable press.
    repeat (3) tick();
    for (int b = 0; b < 3; b++) begin
      button = 1'b1;
      repeat (3) tick();
      button = 1'b0;
      repeat (3) tick();
      check("bounce_state", 32'(state), 32'd4);
    end
    button = 1'b1;      // last rise just after edge L
    repeat (10) tick(); // L+10
    check("btn_l10_state", 32'(state), 32'd4);
    tick();             // L+11
`ifdef RESET_SEQ_BUTTON_EN
    check("btn_l11_state", 32'(state), 32'd1);
    check("btn_l11_mmcm", 32'(mmcm_reset), 32'd1);
    check("btn_l11_sys", 32'(sys_reset), 32'd1);
`else
    check("btn_l11_state", 32'(state), 32'd4);
    check("btn_l11_mmcm", 32'(mmcm_reset), 32'd0);
    check("btn_l11_sys", 32'(sys_reset), 32'd0);
`endif
    check("btn_fault", 32'(fault_count), 32'd1);
    repeat (13) tick(); // L+24: sequence complete either way
    check("btn_l24_state", 32'(state), 32'd4);
    check("btn_l24_sys", 32'(sys_reset), 32'd0);
    button = 1'b0;
    repeat (20) tick();
    check("btn_rel_state", 32'(state), 32'd4);
    check("btn_rel_fault", 32'(fault_count), 32'd1);

    // areset pulse mid-RUN, not aligned to the clock.
    #2;
    areset = 1'b1;
    #1;
    check("ares_sys", 32'(sys_reset), 32'd1);
    check("ares_mmcm", 32'(mmcm_reset), 32'd1);
    check("ares_state", 32'(state), 32'd0);
    check("ares_fault", 32'(fault_count), 32'd0);
    #3;
    areset = 1'b0;      // next rising edge is edge 1
    powerup_check("ares_pwr");

    // Lock never rises: re-pulse every 36 edges until fault_count saturates.
    areset = 1'b1;
    locked = 2'b01;
    repeat (2) tick();
    @(negedge clock);
    areset = 1'b0;
    repeat (36) tick(); // edge 36
    check("to_e36_state", 32'(state), 32'd2);
    check("to_e36_fault", 32'(fault_count), 32'd0);
    tick();             // edge 37 = WAIT_LOCK entry (5) + 32
    check("to_e37_state", 32'(state), 32'd1);
    check("to_e37_mmcm", 32'(mmcm_reset), 32'd1);
    check("to_e37_fault", 32'(fault_count), 32'd1);
    repeat (4) tick();  // edge 41
    check("to_e41_mmcm", 32'(mmcm_reset), 32'd0);
    check("to_e41_state", 32'(state), 32'd2);
    repeat (32) tick(); // edge 73
    check("to_e73_mmcm", 32'(mmcm_reset), 32'd1);
    check("to_e73_fault", 32'(fault_count), 32'd2);
    for (int k = 3; k <= 260; k++) begin
      repeat (36) tick(); // edge 1 + 36*k
      check("to_fault", 32'(fault_count), (k > 255) ? 32'd255 : 32'(k));
      check("to_state", 32'(state), 32'd1);
    end
    check("to_sat_sys", 32'(sys_reset), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
